// File: rtl/la_pwrseq.sv
// rtl/la_pwrseq.sv - staggered power-switch sequencer with isolation and power-good
module la_pwrseq #(
    parameter string PROP  = "DEFAULT",
    parameter int    N     = 4,
    parameter int    DELAY = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    output logic [N-1:0] en,
    output logic         iso,
    output logic         ack,
    output logic         busy
);

    localparam int            CW   = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DELAY - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    // Out-of-range parameters are rejected at elaboration rather than building a broken ramp.
    if (N < 1) begin : g_bad_n
        $error("la_pwrseq: N must be >= 1");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("la_pwrseq: DELAY must be >= 1");
    end
    if (PROP == "") begin : g_bad_prop
        $error("la_pwrseq: PROP must not be empty");
    end

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
            en    <= '0;
            iso   <= 1'b1;
            ack   <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    if (req) begin
                        state <= S_UP;
                        en    <= ONE;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_UP: begin
                    if (!req) begin
                        state <= S_DOWN;
                        cnt   <= '0;
                    end else if (cnt == CMAX) begin
                        cnt <= '0;
                        if (&en) begin
                            state <= S_ON;
                            iso   <= 1'b0;
                            ack   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            en <= (en << 1) | ONE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ON: begin
                    // Isolation is raised on this edge; switches start opening DELAY edges later.
                    if (!req) begin
                        state <= S_DOWN;
                        iso   <= 1'b1;
                        ack   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_DOWN: begin
                    if (req) begin
                        state <= S_UP;
                        cnt   <= '0;
                    end else if (cnt == CMAX) begin
                        cnt <= '0;
                        en  <= en >> 1;
                        if (en == ONE) begin
                            state <= S_OFF;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_OFF;
                    en    <= '0;
                    iso   <= 1'b1;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_pwrseq.sv
// tb/tb_la_pwrseq.sv - bench for la_pwrseq against a segment-level reference model
module tb_la_pwrseq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, req_a, rst_b, req_b;
    logic [3:0] en_a;
    logic [0:0] en_b;
    logic       iso_a, ack_a, busy_a, iso_b, ack_b, busy_b;

    la_pwrseq #(.PROP("DEFAULT"), .N(4), .DELAY(8)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a),
        .en(en_a), .iso(iso_a), .ack(ack_a), .busy(busy_a)
    );

    la_pwrseq #(.PROP("FAST"), .N(1), .DELAY(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b),
        .en(en_b), .iso(iso_b), .ack(ack_b), .busy(busy_b)
    );

    int checks = 0;
    int fails  = 0;

    // Model: number of closed segments, ramp direction, time since last segment event.
    int lvl[2];
    int tmr[2];
    bit dir_up[2];
    bit ramping[2];
    bit pgood[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i, input int n, input int d, input bit r, input bit rs);
        if (rs) begin
            lvl[i] = 0; tmr[i] = 0; ramping[i] = 0; pgood[i] = 0; dir_up[i] = 0;
        end else if (pgood[i]) begin
            if (!r) begin
                pgood[i] = 0; ramping[i] = 1; dir_up[i] = 0; tmr[i] = 0;
            end
        end else if (!ramping[i]) begin
            if (r) begin
                lvl[i] = 1; ramping[i] = 1; dir_up[i] = 1; tmr[i] = 0;
            end
        end else if (r != dir_up[i]) begin
            dir_up[i] = r; tmr[i] = 0;
        end else if (tmr[i] < d - 1) begin
            tmr[i]++;
        end else begin
            tmr[i] = 0;
            if (dir_up[i]) begin
                if (lvl[i] == n) begin
                    ramping[i] = 0; pgood[i] = 1;
                end else begin
                    lvl[i]++;
                end
            end else begin
                lvl[i]--;
                if (lvl[i] == 0) ramping[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("a_en",   32'(en_a),   32'((1 << lvl[0]) - 1));
        chk("a_iso",  32'(iso_a),  32'(!pgood[0]));
        chk("a_ack",  32'(ack_a),  32'(pgood[0]));
        chk("a_busy", 32'(busy_a), 32'(ramping[0]));
        chk("b_en",   32'(en_b),   32'((1 << lvl[1]) - 1));
        chk("b_iso",  32'(iso_b),  32'(!pgood[1]));
        chk("b_ack",  32'(ack_b),  32'(pgood[1]));
        chk("b_busy", 32'(busy_b), 32'(ramping[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(0, 4, 8, req_a, rst_a);
        model_step(1, 1, 1, req_b, rst_b);
        compare_all();
    endtask

    initial begin
        rst_a = 1'b1; req_a = 1'b0; rst_b = 1'b1; req_b = 1'b0;
        tick();
        tick();
        chk("rst_en", 32'(en_a), 32'h0);
        chk("rst_iso", 32'(iso_a), 32'h1);
        chk("rst_ack", 32'(ack_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Boundary instance N=1, DELAY=1
        req_b = 1'b1;
        tick(); chk("b_up_en", 32'(en_b), 32'h1); chk("b_up_ack0", 32'(ack_b), 32'h0);
        tick(); chk("b_up_ack1", 32'(ack_b), 32'h1); chk("b_up_iso", 32'(iso_b), 32'h0);
        req_b = 1'b0;
        tick(); chk("b_dn_iso", 32'(iso_b), 32'h1); chk("b_dn_en1", 32'(en_b), 32'h1);
        tick(); chk("b_dn_en0", 32'(en_b), 32'h0); chk("b_dn_busy", 32'(busy_b), 32'h0);

        // Power-up N=4, DELAY=8
        req_a = 1'b1;
        for (int e = 0; e <= 32; e++) begin
            tick();
            if (e == 0)  chk("up_e0", 32'(en_a), 32'h1);
            if (e == 8)  chk("up_e8", 32'(en_a), 32'h3);
            if (e == 16) chk("up_e16", 32'(en_a), 32'h7);
            if (e == 24) chk("up_e24", 32'(en_a), 32'hf);
            if (e == 31) chk("up_ack31", 32'(ack_a), 32'h0);
            if (e < 32)  chk("up_busy", 32'(busy_a), 32'h1);
        end
        chk("up_ack32", 32'(ack_a), 32'h1);
        chk("up_iso32", 32'(iso_a), 32'h0);

        // Power-down from ON
        req_a = 1'b0;
        for (int e = 0; e <= 32; e++) begin
            tick();
            if (e == 0)  begin chk("dn_iso0", 32'(iso_a), 32'h1); chk("dn_en0", 32'(en_a), 32'hf); end
            if (e == 8)  chk("dn_e8", 32'(en_a), 32'h7);
            if (e == 16) chk("dn_e16", 32'(en_a), 32'h3);
            if (e == 24) chk("dn_e24", 32'(en_a), 32'h1);
        end
        chk("dn_e32", 32'(en_a), 32'h0);
        chk("dn_busy32", 32'(busy_a), 32'h0);

        // Reversal while ramping up
        req_a = 1'b1;
        for (int e = 0; e < 10; e++) tick();
        req_a = 1'b0;
        for (int e = 10; e <= 26; e++) begin
            tick();
            if (e == 10) chk("rv_e10", 32'(en_a), 32'h3);
            if (e == 18) chk("rv_e18", 32'(en_a), 32'h1);
            chk("rv_ack", 32'(ack_a), 32'h0);
        end
        chk("rv_e26", 32'(en_a), 32'h0);
        chk("rv_busy26", 32'(busy_a), 32'h0);

        // Reversal while ramping down from ON
        req_a = 1'b1;
        for (int e = 0; e <= 32; e++) tick();
        req_a = 1'b0;
        for (int e = 0; e < 3; e++) tick();
        req_a = 1'b1;
        for (int e = 3; e <= 11; e++) begin
            tick();
            chk("rd_en", 32'(en_a), 32'hf);
            if (e == 10) chk("rd_ack10", 32'(ack_a), 32'h0);
        end
        chk("rd_ack11", 32'(ack_a), 32'h1);
        chk("rd_iso11", 32'(iso_a), 32'h0);

        // Reset mid-ramp
        req_a = 1'b0;
        for (int e = 0; e <= 32; e++) tick();
        req_a = 1'b1;
        for (int e = 0; e < 12; e++) tick();
        rst_a = 1'b1;
        tick();
        chk("mr_en", 32'(en_a), 32'h0);
        chk("mr_busy", 32'(busy_a), 32'h0);
        rst_a = 1'b0;
        tick();
        chk("mr_restart", 32'(en_a), 32'h1);

        // Randomized traffic checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) req_a = ~req_a;
            rst_a = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            rst_b = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
